song_sequencer: RTL



---
 rtl/song_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/song_sequencer.sv
// song_sequencer: fetches note/length entries from a registered song ROM and
// drives the tone generator note code, with articulation gaps, pause, stop
// and loop support. Every output comes straight from a flop.
module song_sequencer #(
  parameter int TICK_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 1_000_000,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [4:0]        note,
  output logic              playing,
  output logic              done
);

  // Keep counters at least one bit wide so a count of 1 still elaborates.
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP, DONE} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] rom_addr_n;
  logic [4:0]        note_n, cur_note, cur_note_n;
  logic              playing_n, done_n;
  logic [TW-1:0]     tick_cnt, tick_cnt_n;
  logic [GW-1:0]     gap_cnt, gap_cnt_n;
  logic [2:0]        beats_left, beats_left_n;

  // State, counters and registered outputs; reset silences immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rom_addr   <= '0;
      note       <= '0;
      cur_note   <= '0;
      playing    <= 1'b0;
      done       <= 1'b0;
      tick_cnt   <= '0;
      gap_cnt    <= '0;
      beats_left <= '0;
    end else begin
      state      <= state_n;
      rom_addr   <= rom_addr_n;
      note       <= note_n;
      cur_note   <= cur_note_n;
      playing    <= playing_n;
      done       <= done_n;
      tick_cnt   <= tick_cnt_n;
      gap_cnt    <= gap_cnt_n;
      beats_left <= beats_left_n;
    end
  end

  // Next-state and next-output logic; stop overrides everything else.
  always_comb begin
    state_n      = state;
    rom_addr_n   = rom_addr;
    note_n       = 5'd0;
    cur_note_n   = cur_note;
    tick_cnt_n   = tick_cnt;
    gap_cnt_n    = gap_cnt;
    beats_left_n = beats_left;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n    = FETCH;
          rom_addr_n = '0;
        end
      end
      FETCH: state_n = LOAD;
      LOAD: begin
        if (rom_data[7:5] == 3'd0) begin
          // End marker: loop_en only matters at this moment.
          if (loop_en) begin
            state_n    = FETCH;
            rom_addr_n = '0;
          end else begin
            state_n = DONE;
          end
        end else begin
          state_n      = PLAY;
          cur_note_n   = rom_data[4:0];
          note_n       = rom_data[4:0];
          beats_left_n = rom_data[7:5];
          tick_cnt_n   = '0;
        end
      end
      PLAY: begin
        // While paused everything holds and the speaker is silent.
        if (!pause) begin
          note_n = cur_note;
          if (tick_cnt == TW'(TICK_CYCLES - 1)) begin
            tick_cnt_n = '0;
            if (beats_left == 3'd1) begin
              state_n      = GAP;
              gap_cnt_n    = '0;
              note_n       = 5'd0;
              beats_left_n = 3'd0;
            end else begin
              beats_left_n = beats_left - 3'd1;
            end
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end
      GAP: begin
        if (!pause) begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            state_n    = FETCH;
            gap_cnt_n  = '0;
            rom_addr_n = rom_addr + 1'b1;  // wraps naturally at the top
          end else begin
            gap_cnt_n = gap_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (stop) begin
      state_n    = IDLE;
      note_n     = 5'd0;
      rom_addr_n = '0;
    end

    playing_n = (state_n == FETCH) || (state_n == LOAD) ||
                (state_n == PLAY)  || (state_n == GAP);
    done_n    = (state_n == DONE);
  end

endmodule
